// File: rtl/cpu_pkg.sv
// Shared types for the instruction-fetch stage.
// Word width, reset PC default, FSM states and buffer entry.
package cpu_pkg;

  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALTED
  } fetch_state_e;

  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between fetch and imem.
// Fetch is master: it drives address and read enable.
interface fetch_unit_if;
  import cpu_pkg::*;

  logic [WORD_W-1:0] imem_addr;
  logic              imem_rd_en;
  logic [WORD_W-1:0] imem_instr;
  logic              imem_ready;

  modport master (
    output imem_addr,
    output imem_rd_en,
    input  imem_instr,
    input  imem_ready
  );

  modport slave (
    input  imem_addr,
    input  imem_rd_en,
    output imem_instr,
    output imem_ready
  );

endinterface

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of {instr, pc} between imem and decode.
// Push into a full FIFO is only honoured together with a pop.
module fetch_buffer
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t head,
  output logic [1:0]   count,
  output logic         empty,
  output logic         full
);

  fetch_entry_t mem_q [2];
  fetch_entry_t mem_d [2];
  logic         hd_q, hd_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         do_push, do_pop;

  always_comb begin
    empty   = cnt_q == 2'd0;
    full    = cnt_q == 2'd2;
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    mem_d   = mem_q;
    hd_d    = hd_q;
    cnt_d   = cnt_q;
    if (flush) begin
      cnt_d = 2'd0;
      hd_d  = 1'b0;
    end else begin
      // tail slot is (head + count) mod 2
      if (do_push) mem_d[hd_q ^ cnt_q[0]] = wdata;
      if (do_pop) hd_d = ~hd_q;
      cnt_d = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign head  = mem_q[hd_q];
  assign count = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      hd_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q <= mem_d;
      hd_q  <= hd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, one-word imem reads, 2-entry
// output buffer, redirect flush and halt.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC  = RESET_PC_DEF,
  parameter int                BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  fetch_unit_if.master      imem,
  input  logic              redirect_valid,
  input  logic [WORD_W-1:0] redirect_pc,
  input  logic              halt_req,
  input  logic              id_stall,
  output logic              if_valid,
  output logic [WORD_W-1:0] if_instr,
  output logic [WORD_W-1:0] if_pc,
  output logic              if_halted
);

  localparam logic [2:0] DEPTH = 3'(BUF_DEPTH);

  fetch_state_e      state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] iss_pc_q, iss_pc_d;
  logic              inflight_q, inflight_d;
  logic              discard_q, discard_d;

  logic [WORD_W-1:0] addr;
  logic [2:0]        load;
  logic              room, issue, push, pop;
  logic [1:0]        count;
  logic              empty, full;
  fetch_entry_t      wdata, head;

  fetch_buffer u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata (wdata),
    .head  (head),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  always_comb begin
    addr  = redirect_valid ? redirect_pc : pc_q;
    load  = {1'b0, count} + {2'b00, inflight_q};
    pop   = !empty && !id_stall && !redirect_valid && !rst;
    room  = (load < DEPTH) || (load == DEPTH && pop);
    issue = !rst && (redirect_valid ||
            (state_q == RUN && !halt_req && room));
    // the word returning in a redirect cycle is stale
    push  = imem.imem_ready && !discard_q &&
            !redirect_valid && !rst;
    wdata = '{instr: imem.imem_instr, pc: iss_pc_q};

    pc_d       = issue ? addr + 32'd1 : pc_q;
    iss_pc_d   = issue ? addr : iss_pc_q;
    inflight_d = issue;
    discard_d  = 1'b0;

    state_d = state_q;
    unique case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (!redirect_valid && halt_req) state_d = HALTED;
      HALTED:  if (redirect_valid) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  assign imem.imem_addr  = addr;
  assign imem.imem_rd_en = issue;

  assign if_valid  = !empty && !rst;
  assign if_instr  = if_valid ? head.instr : '0;
  assign if_pc     = if_valid ? head.pc : '0;
  assign if_halted = state_q == HALTED && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      iss_pc_q   <= '0;
      inflight_q <= 1'b0;
      discard_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      iss_pc_q   <= iss_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && full && !pop))
        else $error("fetch buffer overflow");
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random
// stimulus against a queue-based reference model.
module tb_fetch_unit;
  import cpu_pkg::*;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halt_req = 1'b0;
  logic        id_stall = 1'b0;
  logic        if_valid, if_halted;
  logic [31:0] if_instr, if_pc;

  fetch_unit_if imem();

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem           (imem),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .id_stall       (id_stall),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_halted      (if_halted)
  );

  always #5 clk = ~clk;

  ent_t        q[$];
  bit          m_boot = 1'b1;
  bit          m_halt = 1'b0;
  bit          m_rd = 1'b0;
  logic [31:0] m_pc = '0;
  logic [31:0] m_rdpc = '0;
  bit          e_valid, e_rd, e_halted, e_pop;
  logic [31:0] e_addr;

  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  bit          armed = 1'b0;
  logic [31:0] arm_pc;
  int          arm_lat, arm_cnt;
  bit          mem_rd;
  logic [31:0] mem_addr;

  function automatic logic [31:0] word(logic [31:0] a);
    return 32'hA000_0000 + a;
  endfunction

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)",
                  tag, got, exp, cyc);
  endtask

  task automatic arm(logic [31:0] pc, int lat);
    armed   = 1'b1;
    arm_pc  = pc;
    arm_lat = lat;
    arm_cnt = 0;
  endtask

  task automatic model_comb();
    int room;
    e_valid  = !rst && q.size() > 0;
    e_pop    = e_valid && !id_stall && !redirect_valid;
    room     = 2 - q.size() - int'(m_rd) + int'(e_pop);
    e_rd     = !rst && (redirect_valid ||
               (!m_boot && !m_halt && !halt_req && room > 0));
    e_addr   = redirect_valid ? redirect_pc : m_pc;
    e_halted = !rst && m_halt;
  endtask

  task automatic model_seq();
    ent_t e;
    if (rst) begin
      m_pc   = RESET_PC_DEF;
      q.delete();
      m_rd   = 1'b0;
      m_boot = 1'b1;
      m_halt = 1'b0;
      return;
    end
    if (redirect_valid) q.delete();
    else begin
      if (e_pop) void'(q.pop_front());
      if (m_rd) begin
        e.instr = word(m_rdpc);
        e.pc    = m_rdpc;
        q.push_back(e);
      end
    end
    if (q.size() > 2) chk("model_occupancy", q.size(), 2);
    if (e_rd) begin
      m_rdpc = e_addr;
      m_pc   = e_addr + 32'd1;
    end
    m_rd = e_rd;
    if (redirect_valid) begin
      m_boot = 1'b0;
      m_halt = 1'b0;
    end else if (m_boot) m_boot = 1'b0;
    else if (halt_req) m_halt = 1'b1;
  endtask

  task automatic cycle();
    #1;
    model_comb();
    chk("if_valid", 32'(if_valid), 32'(e_valid));
    chk("if_halted", 32'(if_halted), 32'(e_halted));
    chk("imem_rd_en", 32'(imem.imem_rd_en), 32'(e_rd));
    if (e_valid) begin
      chk("if_pc", if_pc, q[0].pc);
      chk("if_instr", if_instr, q[0].instr);
    end else begin
      chk("if_pc_idle", if_pc, 32'h0);
    end
    if (e_rd) chk("imem_addr", imem.imem_addr, e_addr);
    if (armed) begin
      if (if_valid) begin
        chk("first_pc", if_pc, arm_pc);
        if (arm_lat >= 0) chk("first_lat", arm_cnt, arm_lat);
        armed = 1'b0;
      end else if (++arm_cnt > 20) begin
        chk("first_pc_timeout", 32'(arm_cnt), 32'd0);
        armed = 1'b0;
      end
    end
    mem_rd   = imem.imem_rd_en;
    mem_addr = imem.imem_addr;
    @(posedge clk);
    model_seq();
    cyc++;
    #1;
    imem.imem_ready = mem_rd;
    imem.imem_instr = mem_rd ? word(mem_addr) : $urandom;
    @(negedge clk);
  endtask

  initial begin
    imem.imem_ready = 1'b0;
    imem.imem_instr = '0;
    @(negedge clk);

    rst = 1'b1;
    repeat (2) cycle();
    rst = 1'b0;
    arm(32'h0, 3);
    repeat (8) cycle();

    id_stall = 1'b1;
    repeat (5) cycle();
    chk("stall_rd_low", 32'(imem.imem_rd_en), 32'd0);
    id_stall = 1'b0;
    repeat (6) cycle();

    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    cycle();
    redirect_valid = 1'b0;
    arm(32'h40, 1);
    repeat (6) cycle();

    redirect_valid = 1'b1;
    redirect_pc    = 32'h10;
    cycle();
    redirect_pc    = 32'h20;
    cycle();
    redirect_valid = 1'b0;
    arm(32'h20, 1);
    repeat (6) cycle();

    halt_req = 1'b1;
    cycle();
    halt_req = 1'b0;
    repeat (5) cycle();
    chk("halted_flag", 32'(if_halted), 32'd1);
    chk("halted_no_rd", 32'(imem.imem_rd_en), 32'd0);
    chk("halted_drained", 32'(if_valid), 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8;
    cycle();
    redirect_valid = 1'b0;
    arm(32'h8, 1);
    repeat (6) cycle();

    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    arm(RESET_PC_DEF, 3);
    repeat (8) cycle();

    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    cycle();
    redirect_valid = 1'b0;
    repeat (6) cycle();

    for (int i = 0; i < 3000; i++) begin
      rst            = ($urandom % 64) == 0;
      redirect_valid = ($urandom % 12) == 0;
      redirect_pc    = ($urandom % 4 == 0) ?
                       32'hFFFF_FFFC + ($urandom % 4) :
                       $urandom;
      halt_req       = ($urandom % 40) == 0;
      id_stall       = ($urandom % 3) == 0;
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
